wb_stage_gen: RTL and testbench

//  Parametrised writeback stage: final pipeline stage before the register file. Aligns,

---
 rtl/wb_pkg.sv | 6 +
 rtl/wb_load_align.sv | 27 ++
 rtl/wb_stage_gen.sv | 109 ++++++++++
 tb/tb_wb_stage_gen.sv | 135 +++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared load-size and FSM state types for the writeback stage.
package wb_pkg;
  typedef enum logic [1:0] {LD_WORD = 2'd0, LD_HALF = 2'd1, LD_BYTE = 2'd2} ld_size_e;
  typedef enum logic {S_IDLE = 1'b0, S_HI = 1'b1} wb_state_e;
  localparam logic [3:0] EXC_INT_NIBBLE = 4'hF;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: shifts (optionally merging a high beat), masks and extends load data.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = 2
) (
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_hi,
  input  logic [OFFW-1:0] i_off,
  input  logic            i_merge,
  input  ld_size_e        i_size,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_data
);
  localparam int SW = OFFW + 4;
  logic [SW-1:0]   w_rsh;
  logic [SW-1:0]   w_lsh;
  logic [XLEN-1:0] w_raw;
  assign w_rsh = SW'({i_off, 3'b000});
  assign w_lsh = SW'(XLEN) - w_rsh;
  // offset 0 makes w_lsh == XLEN, which shifts the high beat out entirely
  assign w_raw = (i_merge ? (i_hi << w_lsh) : '0) | (i_lo >> w_rsh);
  always_comb
    o_data = (i_size == LD_BYTE) ? {{(XLEN-8){i_signed & w_raw[7]}}, w_raw[7:0]} :
             (i_size == LD_HALF) ? {{(XLEN-16){i_signed & w_raw[15]}}, w_raw[15:0]} : w_raw;
endmodule

// File: rtl/wb_stage_gen.sv
// wb_stage_gen: writeback stage with load alignment, split-load merge and control flags.
// Optional WB_FWD_HIST_EN adds registered last-write history for decode forwarding.
module wb_stage_gen
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NWP  = 2,
  parameter int RAW  = 5,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                in_valid,
  input  logic [NWP*RAW-1:0]  in_tgt,
  input  logic [NWP*XLEN-1:0] in_alu,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                no_wb,
  input  logic [1:0]          ld_size,
  input  logic                ld_signed,
  input  logic                misaligned,
  input  logic [OFFW-1:0]     addr_lo,
  input  logic [XLEN-1:0]     mem_data,
  input  logic [7:0]          exc_in,
  input  logic                is_rfe,
  input  logic                rfi_mode,
  output logic [NWP-1:0]      we,
  output logic [NWP*RAW-1:0]  wr_tgt,
  output logic [NWP*XLEN-1:0] wr_data,
  output logic                exc_flag,
  output logic                int_flag,
  output logic                rfe_flag,
  output logic                rfi_flag,
  output logic                split_busy
`ifdef WB_FWD_HIST_EN
  ,
  output logic [NWP*RAW-1:0]  hist_tgt,
  output logic [NWP*XLEN-1:0] hist_data
`endif
);
  wb_state_e       r_state, w_next;
  logic [XLEN-1:0] r_lo_buf;
  logic [OFFW-1:0] r_off_buf;
  ld_size_e        r_size;
  logic            r_signed;
  logic [XLEN-1:0] w_ld;
  logic            w_exc, w_busy, w_beat, w_split_start;
  assign w_exc         = |exc_in;
  assign w_busy        = (r_state == S_HI);
  assign w_beat        = in_valid & ~stall;
  assign w_split_start = ~w_busy & w_beat & is_load & misaligned & ~w_exc;
  assign split_busy    = w_busy;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = w_busy ? (w_beat ? S_IDLE : S_HI) : (w_split_start ? S_HI : S_IDLE);
  always_ff @(posedge clk)
    if (rst) begin
      r_lo_buf  <= '0;
      r_off_buf <= '0;
      r_size    <= LD_WORD;
      r_signed  <= 1'b0;
    end else if (w_split_start) begin
      r_lo_buf  <= mem_data;
      r_off_buf <= addr_lo;
      r_size    <= ld_size_e'(ld_size);
      r_signed  <= ld_signed;
    end
  // in S_HI the buffered low beat and its size/offset drive the shared aligner
  wb_load_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
    .i_lo    (w_busy ? r_lo_buf : mem_data),
    .i_hi    (mem_data),
    .i_off   (w_busy ? r_off_buf : addr_lo),
    .i_merge (w_busy),
    .i_size  (w_busy ? r_size : ld_size_e'(ld_size)),
    .i_signed(w_busy ? r_signed : ld_signed),
    .o_data  (w_ld)
  );
  for (genvar p = 0; p < NWP; p++) begin : g_port
    logic [RAW-1:0] w_tgt;
    assign w_tgt = in_tgt[p*RAW +: RAW];
    assign wr_tgt[p*RAW +: RAW] = w_tgt;
    assign we[p] = w_beat & ~no_wb & (|w_tgt) & ~w_exc & ~((p == 0) & (is_store | w_split_start));
    assign wr_data[p*XLEN +: XLEN] = ((p == 0) & (is_load | w_busy)) ? w_ld : in_alu[p*XLEN +: XLEN];
  end
  assign exc_flag = in_valid & w_exc;
  assign int_flag = in_valid & (exc_in[7:4] == EXC_INT_NIBBLE);
  assign rfe_flag = in_valid & is_rfe;
  assign rfi_flag = rfe_flag & rfi_mode;
`ifdef WB_FWD_HIST_EN
  logic [NWP*RAW-1:0]  r_hist_tgt, w_hist_tgt;
  logic [NWP*XLEN-1:0] r_hist_data;
  for (genvar q = 0; q < NWP; q++) begin : g_hist
    assign w_hist_tgt[q*RAW +: RAW] = we[q] ? wr_tgt[q*RAW +: RAW] : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_hist_tgt  <= '0;
      r_hist_data <= '0;
    end else if (~stall) begin
      r_hist_tgt  <= w_hist_tgt;
      r_hist_data <= wr_data;
    end
  assign hist_tgt  = r_hist_tgt;
  assign hist_data = r_hist_data;
`endif
endmodule

// File: tb/tb_wb_stage_gen.sv
// tb_wb_stage_gen: scoreboard bench for wb_stage_gen with default parameters.
module tb_wb_stage_gen;
  logic        clk = 0;
  logic        rst, stall, in_valid, is_load, is_store, no_wb, ld_signed, misaligned;
  logic        is_rfe, rfi_mode;
  logic [9:0]  in_tgt;
  logic [63:0] in_alu;
  logic [1:0]  ld_size, addr_lo;
  logic [31:0] mem_data;
  logic [7:0]  exc_in;
  logic [1:0]  we;
  logic [9:0]  wr_tgt;
  logic [63:0] wr_data;
  logic        exc_flag, int_flag, rfe_flag, rfi_flag, split_busy;
  int          n_chk = 0, n_pass = 0;
  typedef struct {
    string       tag;
    logic [1:0]  we;
    logic [31:0] d0;
    logic        chk_d0;
    logic [31:0] d1;
    logic        chk_d1;
    logic [3:0]  flags;
    logic        busy;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  wb_stage_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_tgt(in_tgt),
    .in_alu(in_alu), .is_load(is_load), .is_store(is_store), .no_wb(no_wb),
    .ld_size(ld_size), .ld_signed(ld_signed), .misaligned(misaligned),
    .addr_lo(addr_lo), .mem_data(mem_data), .exc_in(exc_in), .is_rfe(is_rfe),
    .rfi_mode(rfi_mode), .we(we), .wr_tgt(wr_tgt), .wr_data(wr_data),
    .exc_flag(exc_flag), .int_flag(int_flag), .rfe_flag(rfe_flag),
    .rfi_flag(rfi_flag), .split_busy(split_busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] model_ld(logic [31:0] mem, logic [1:0] off, logic [1:0] sz, logic sgn);
    logic [31:0] s;
    s = mem >> (8 * off);
    if (sz == 2'd2) return sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    if (sz == 2'd1) return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
    return s;
  endfunction
  task automatic clr();
    rst = 0; stall = 0; in_valid = 0; is_load = 0; is_store = 0; no_wb = 0;
    ld_signed = 0; misaligned = 0; is_rfe = 0; rfi_mode = 0; in_tgt = '0;
    in_alu = '0; ld_size = 0; addr_lo = 0; mem_data = '0; exc_in = '0;
  endtask
  task automatic expect_beat(input string tag, input logic [1:0] ew, input logic [31:0] d0,
                             input logic c0, input logic [31:0] d1, input logic c1,
                             input logic [3:0] fl, input logic busy);
    exp_t e;
    e.tag = tag; e.we = ew; e.d0 = d0; e.chk_d0 = c0; e.d1 = d1; e.chk_d1 = c1;
    e.flags = fl; e.busy = busy;
    sb.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    #2;
    e = sb.pop_front();
    check({e.tag, ".we"}, 64'(we), 64'(e.we));
    check({e.tag, ".busy"}, 64'(split_busy), 64'(e.busy));
    check({e.tag, ".flags"}, 64'({exc_flag, int_flag, rfe_flag, rfi_flag}), 64'(e.flags));
    if (e.chk_d0) check({e.tag, ".d0"}, 64'(wr_data[31:0]), 64'(e.d0));
    if (e.chk_d1) check({e.tag, ".d1"}, 64'(wr_data[63:32]), 64'(e.d1));
    @(negedge clk);
    clr();
  endtask
  task automatic split_lo();
    in_valid = 1; is_load = 1; misaligned = 1; addr_lo = 1; mem_data = 32'h44332211;
    in_tgt = 10'd3;
  endtask
  task automatic split_hi();
    in_valid = 1; is_load = 1; mem_data = 32'h88776655; in_tgt = 10'd3;
  endtask
  initial begin
    clr();
    rst = 1;
    repeat (2) @(negedge clk);
    expect_beat("reset", 2'b00, 0, 0, 0, 0, 4'h0, 0); rst = 1; step();
    in_valid = 1; is_load = 1; mem_data = 32'hDEADBEEF; in_tgt = 10'd3;
    expect_beat("lw_aligned", 2'b01, 32'hDEADBEEF, 1, 0, 0, 4'h0, 0); step();
    in_valid = 1; is_load = 1; ld_size = 2; ld_signed = 1; addr_lo = 2;
    mem_data = 32'h0080_0000; in_tgt = 10'd1;
    expect_beat("lb_signed", 2'b01, 32'hFFFF_FF80, 1, 0, 0, 4'h0, 0); step();
    in_valid = 1; is_load = 1; ld_size = 1; addr_lo = 2; mem_data = 32'h0080_0000; in_tgt = 10'd1;
    expect_beat("lh_unsigned", 2'b01, 32'h0000_0080, 1, 0, 0, 4'h0, 0); step();
    split_lo(); expect_beat("split_lo", 2'b00, 0, 0, 0, 0, 4'h0, 0); step();
    split_hi(); expect_beat("split_hi", 2'b01, 32'h55443322, 1, 0, 0, 4'h0, 1); step();
    expect_beat("split_done", 2'b00, 0, 0, 0, 0, 4'h0, 0); step();
    split_lo(); expect_beat("gap_lo", 2'b00, 0, 0, 0, 0, 4'h0, 0); step();
    mem_data = 32'hCAFEF00D; in_tgt = 10'd3;
    expect_beat("gap_bub1", 2'b00, 0, 0, 0, 0, 4'h0, 1); step();
    expect_beat("gap_bub2", 2'b00, 0, 0, 0, 0, 4'h0, 1); step();
    in_valid = 1; stall = 1; in_tgt = 10'd3; mem_data = 32'h12345678;
    expect_beat("gap_stall", 2'b00, 0, 0, 0, 0, 4'h0, 1); step();
    split_hi(); expect_beat("gap_hi", 2'b01, 32'h55443322, 1, 0, 0, 4'h0, 1); step();
    split_lo(); expect_beat("rst_lo", 2'b00, 0, 0, 0, 0, 4'h0, 0); step();
    rst = 1; expect_beat("rst_mid", 2'b00, 0, 0, 0, 0, 4'h0, 1); step();
    in_valid = 1; is_load = 1; mem_data = 32'h88776655; in_tgt = 10'd3;
    expect_beat("rst_after", 2'b01, 32'h88776655, 1, 0, 0, 4'h0, 0); step();
    in_valid = 1; exc_in = 8'hF2; in_tgt = 10'd5 | (10'd6 << 5);
    expect_beat("exc_int", 2'b00, 0, 0, 0, 0, 4'b1100, 0); step();
    in_valid = 1; exc_in = 8'h13; is_load = 1; misaligned = 1; in_tgt = 10'd5;
    expect_beat("exc_noint", 2'b00, 0, 0, 0, 0, 4'b1000, 0); step();
    in_valid = 1; is_store = 1; in_tgt = 10'd3 | (10'd4 << 5); in_alu = {32'hA5A5_0001, 32'h1111_2222};
    expect_beat("store", 2'b10, 0, 0, 32'hA5A5_0001, 1, 4'h0, 0); step();
    in_valid = 1; in_tgt = 10'd7 | (10'd9 << 5); in_alu = {32'h0BAD_F00D, 32'h7777_8888};
    expect_beat("alu2", 2'b11, 32'h7777_8888, 1, 32'h0BAD_F00D, 1, 4'h0, 0); step();
    in_valid = 1; no_wb = 1; in_tgt = 10'd7 | (10'd9 << 5);
    expect_beat("no_wb", 2'b00, 0, 0, 0, 0, 4'h0, 0); step();
    in_valid = 1; in_tgt = 10'd9 << 5; in_alu = {32'h1, 32'h2};
    expect_beat("tgt_zero", 2'b10, 0, 0, 32'h1, 1, 4'h0, 0); step();
    in_valid = 1; is_rfe = 1; rfi_mode = 1;
    expect_beat("rfi", 2'b00, 0, 0, 0, 0, 4'b0011, 0); step();
    is_rfe = 1; exc_in = 8'hF0;
    expect_beat("flags_bubble", 2'b00, 0, 0, 0, 0, 4'h0, 0); step();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] m;
      logic [1:0]  o, s;
      logic        g;
      m = $urandom; o = 2'($urandom_range(0, 3)); s = 2'($urandom_range(0, 2)); g = 1'($urandom);
      in_valid = 1; is_load = 1; mem_data = m; addr_lo = o; ld_size = s; ld_signed = g; in_tgt = 10'd2;
      expect_beat($sformatf("rnd%0d", i), 2'b01, model_ld(m, o, s, g), 1, 0, 0, 4'h0, 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
